instruction_encoder: RTL and testbench
======================================

# instruction_encoder

Packs decoded instruction fields (format, register indices, funct3, full 32-bit immediate) into a 32-bit RV32 instruction word. It is the exact inverse of the immediate generator's field mapping. It sits between the test/boot program source and the instruction memory write port, accepts one field bundle per valid/ready transfer and emits one registered instruction word per transfer. Each word is tagged with an auto-incrementing instruction-memory word address. Out-of-range or malformed immediates are rejected and counted rather than emitted.

## Interface
- ADDR_W, 10, width of the instruction-memory word address counter
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous: zero address counter, error count, sticky flag; drop pending output
- in_valid  input  1  field bundle valid
- in_ready  output  1  bundle accepted when in_valid && in_ready
- fmt  input  3  0=S store, 1=I load, 2=I ALU, 3=SB branch, 4=UJ jal, 5-7 illegal
- rd, rs1, rs2  input  5 each  register indices
- funct3  input  3  funct3 field
- imm  input  32  signed immediate, full byte offset
- out_valid  output  1  instr/out_addr valid
- out_ready  input  1  consumer accepts when out_valid && out_ready
- instr  output  32  encoded instruction
- out_addr  output  ADDR_W  word address for instr
- err_pulse  output  1  one-cycle pulse: last accepted bundle rejected
- err_sticky  output  1  set on any rejection, cleared by rst/clear
- err_count  output  8  saturating rejection count

## Operation
- Opcode by fmt: S 0100011, I-load 0000011, I-ALU 0010011, SB 1100011, UJ 1101111.
- S: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0].
- I: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd.
- SB: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:8]=imm[4:1], [7]=imm[11].
- UJ: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], [11:7]=rd.
- The range check applies to the full 32-bit imm, not only the encoded bits. S/I: imm must lie in -2048..2047. SB: -4096..4094 and imm[0]=0. UJ: -1048576..1048574 and imm[0]=0.
- Rejection triggers: fmt 5-7 or a failed range check. A rejected bundle is consumed (handshake completes) but produces no output. It also pulses err_pulse, sets err_sticky, and increments err_count, which saturates at 255.
- Output register is a single entry. in_ready = !clear && (!out_valid || out_ready).
- Address counter: out_addr holds the address of the current output word. It increments by 1 on each output transfer (out_valid && out_ready) and wraps from 2^ADDR_W-1 to 0.
- clear has priority over everything. In the cycle clear is high: in_ready=0, out_valid falls next cycle, and no counter increments.

## Timing
- Reset values: in_ready=1 once rst deasserts, out_valid=0, instr=0, out_addr=0, err_pulse=0, err_sticky=0, err_count=0.
- Latency: bundle accepted at edge N → out_valid=1 with instr after edge N (visible in cycle N+1). A rejection asserts err_pulse in cycle N+1 for exactly one cycle.
- Throughput: 1 bundle/cycle when out_ready held high. A simultaneous output transfer and input accept is allowed.
- Backpressure: while out_valid && !out_ready, instr and out_addr are held stable and in_ready=0.
- A rejected bundle accepted while the output is free leaves out_valid=0. A rejected bundle arriving with an output transfer in the same cycle still clears out_valid.
- rst mid-operation: all state returns to reset values immediately. The pending word is lost.

## Test plan
- Reset → all outputs at reset values. Then S fmt=0, funct3=010, rs1=1, rs2=2, imm=4 → instr 0x0020A223, out_addr 0 one cycle later.
- Back-to-back with out_ready=1: I-ALU rd=5, rs1=0, funct3=0, imm=-1, then SB rs1=1, rs2=2, funct3=0, imm=-4, then UJ rd=1, imm=8 → instrs 0xFFF00293, 0xFE208EE3, 0x008000EF on consecutive cycles at addresses 0, 1, 2.
- out_ready held low 3 cycles with a word pending → in_ready=0, instr/out_addr stable, and no new bundle is accepted until out_ready rises.
- Rejections: I imm=2048, SB imm=3, fmt=6 → no out_valid, three err_pulse cycles, err_count=3, err_sticky=1. The next valid bundle encodes normally at the unadvanced address.
- Wrap/saturate: ADDR_W=2, five transfers → addresses 0, 1, 2, 3, 0. 300 rejections → err_count=255.
- clear with a pending word and in_valid high → in_ready=0, out_valid=0 next cycle, out_addr/err_count/err_sticky all 0. Assert rst mid-backpressure → immediate reset values.

Source files
------------

// File: rtl/instruction_encoder.sv
// Packs decoded RV32 instruction fields into a 32-bit word behind a single-entry
// valid/ready output register, tagging each word with an auto-incrementing address.
`timescale 1ns/1ps
module instruction_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [7:0]        err_count
);

  localparam logic [2:0] FMT_S  = 3'd0;
  localparam logic [2:0] FMT_IL = 3'd1;
  localparam logic [2:0] FMT_IA = 3'd2;
  localparam logic [2:0] FMT_SB = 3'd3;
  localparam logic [2:0] FMT_UJ = 3'd4;

  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_IL = 7'b0000011;
  localparam logic [6:0] OP_IA = 7'b0010011;
  localparam logic [6:0] OP_SB = 7'b1100011;
  localparam logic [6:0] OP_UJ = 7'b1101111;

  // Range is checked on the whole 32-bit value so high bits that would be
  // silently dropped by the encoding still cause a rejection.
  function automatic logic imm_fits(input logic [2:0] f, input logic signed [31:0] v);
    logic ok;
    case (f)
      FMT_S, FMT_IL, FMT_IA: ok = (v >= -32'sd2048) && (v <= 32'sd2047);
      FMT_SB:                ok = (v >= -32'sd4096) && (v <= 32'sd4094) && !v[0];
      FMT_UJ:                ok = (v >= -32'sd1048576) && (v <= 32'sd1048574) && !v[0];
      default:               ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] encode(input logic [2:0] f, input logic [4:0] d,
                                         input logic [4:0] s1, input logic [4:0] s2,
                                         input logic [2:0] f3, input logic [31:0] v);
    logic [31:0] w;
    case (f)
      FMT_S:   w = {v[11:5], s2, s1, f3, v[4:0], OP_S};
      FMT_IL:  w = {v[11:0], s1, f3, d, OP_IL};
      FMT_IA:  w = {v[11:0], s1, f3, d, OP_IA};
      FMT_SB:  w = {v[12], v[10:5], s2, s1, f3, v[4:1], v[11], OP_SB};
      FMT_UJ:  w = {v[20], v[10:1], v[11], v[19:12], d, OP_UJ};
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic signed [31:0] imm_p0;
  logic [31:0]        instr_p0;
  logic               ok_p0;
  logic               accept;
  logic               xfer;

  logic               vld_p1;
  logic [31:0]        instr_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic               err_p1;
  logic               sticky_p1;
  logic [7:0]         cnt_p1;

  // Stage 0: combinational encode and validity check of the incoming bundle
  always_comb begin
    imm_p0   = signed'(imm);
    ok_p0    = imm_fits(fmt, imm_p0);
    instr_p0 = encode(fmt, rd, rs1, rs2, funct3, imm);
    in_ready = !clear && (!vld_p1 || out_ready);
    accept   = in_valid && in_ready;
    xfer     = vld_p1 && out_ready;
  end

  // Stage 1: single-entry output register, address counter and error tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      instr_p1  <= '0;
      addr_p1   <= '0;
      err_p1    <= 1'b0;
      sticky_p1 <= 1'b0;
      cnt_p1    <= '0;
    end else if (clear) begin
      vld_p1    <= 1'b0;
      addr_p1   <= '0;
      err_p1    <= 1'b0;
      sticky_p1 <= 1'b0;
      cnt_p1    <= '0;
    end else begin
      if (xfer) addr_p1 <= addr_p1 + ADDR_W'(1);
      err_p1 <= accept && !ok_p0;
      if (accept) begin
        vld_p1 <= ok_p0;
        if (ok_p0) begin
          instr_p1 <= instr_p0;
        end else begin
          sticky_p1 <= 1'b1;
          cnt_p1    <= sat_inc(cnt_p1);
        end
      end else if (xfer) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid  = vld_p1;
  assign instr      = instr_p1;
  assign out_addr   = addr_p1;
  assign err_pulse  = err_p1;
  assign err_sticky = sticky_p1;
  assign err_count  = cnt_p1;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed scoreboard bench for instruction_encoder (ADDR_W=2 to exercise address wrap).
`timescale 1ns/1ps
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  fmt, funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, instr;
  logic [1:0]  out_addr;
  logic        err_pulse, err_sticky;
  logic [7:0]  err_count;

  instruction_encoder #(.ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses   = 0;
  int acc_cyc  = 0;
  logic [33:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer and counts err pulses.
  always @(negedge clk) begin
    if (!rst && err_pulse) pulses++;
    if (!rst && !clear && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", instr, 32'hDEADBEEF);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("instr", instr, e[33:2]);
        check("out_addr", {30'd0, out_addr}, {30'd0, e[1:0]});
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fmt = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; imm = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive(input logic [2:0] f, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im);
    fmt = f; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; imm = im; in_valid = 1'b1;
  endtask

  // Presents a bundle, waits (bounded) for acceptance, queues the expected word.
  task automatic send(input logic [2:0] f, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im,
                      input bit good, input logic [31:0] ei, input logic [1:0] ea);
    int waited = 0;
    drive(f, d, s1, s2, f3, im);
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    if (good) exp_q.push_back({ei, ea});
    @(posedge clk);
    #1 in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  initial begin
    int c0;
    do_reset();

    // Reset values
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_out_addr", {30'd0, out_addr}, 32'd0);
    check("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    check("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    @(posedge clk); #1;

    // First store, one-cycle latency
    send(3'd0, 5'd0, 5'd1, 5'd2, 3'b010, 32'd4, 1'b1, 32'h0020A223, 2'd0);
    check("s_latency_valid", {31'd0, out_valid}, 32'd1);
    check("s_latency_instr", instr, 32'h0020A223);
    idle(2);

    // Back-to-back I-ALU, SB, UJ
    do_reset();
    send(3'd2, 5'd5, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00293, 2'd0);
    c0 = acc_cyc;
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3, 2'd1);
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8, 1'b1, 32'h008000EF, 2'd2);
    check("b2b_cycles", acc_cyc - c0, 32'd2);
    idle(2);

    // Backpressure: pending word held for three cycles, next bundle blocked
    do_reset();
    out_ready = 1'b0;
    send(3'd0, 5'd0, 5'd1, 5'd2, 3'b010, 32'd4, 1'b1, 32'h0020A223, 2'd0);
    drive(3'd2, 5'd5, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_instr", instr, 32'h0020A223);
      check("bp_out_addr", {30'd0, out_addr}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'd2, 5'd5, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00293, 2'd1);
    idle(2);

    // Rejections: no output, three pulses, next valid word at address 0
    do_reset();
    pulses = 0;
    send(3'd1, 5'd3, 5'd1, 5'd0, 3'd2, 32'd2048, 1'b0, 32'd0, 2'd0);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3, 1'b0, 32'd0, 2'd0);
    send(3'd6, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1'b0, 32'd0, 2'd0);
    check("rej_out_valid", {31'd0, out_valid}, 32'd0);
    idle(2);
    check("rej_pulses", pulses, 32'd3);
    check("rej_pulse_low", {31'd0, err_pulse}, 32'd0);
    check("rej_err_count", {24'd0, err_count}, 32'd3);
    check("rej_err_sticky", {31'd0, err_sticky}, 32'd1);
    send(3'd0, 5'd0, 5'd1, 5'd2, 3'b010, 32'd4, 1'b1, 32'h0020A223, 2'd0);
    idle(2);

    // Address wrap and error-count saturation
    do_reset();
    for (int i = 0; i < 5; i++)
      send(3'd0, 5'd0, 5'd1, 5'd2, 3'b010, 32'd4, 1'b1, 32'h0020A223, 2'(i));
    for (int i = 0; i < 300; i++)
      send(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1'b0, 32'd0, 2'd0);
    idle(2);
    check("sat_err_count", {24'd0, err_count}, 32'd255);
    check("wrap_addr_after", {30'd0, out_addr}, 32'd1);

    // clear with a pending word and in_valid high
    out_ready = 1'b0;
    send(3'd0, 5'd0, 5'd1, 5'd2, 3'b010, 32'd4, 1'b1, 32'h0020A223, 2'd1);
    drive(3'd2, 5'd5, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF);
    clear = 1'b1;
    @(negedge clk);
    check("clr_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("clr_out_valid", {31'd0, out_valid}, 32'd0);
    check("clr_out_addr", {30'd0, out_addr}, 32'd0);
    check("clr_err_count", {24'd0, err_count}, 32'd0);
    check("clr_err_sticky", {31'd0, err_sticky}, 32'd0);
    idle(1);

    // Asynchronous reset during backpressure
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8, 1'b1, 32'h008000EF, 2'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_instr", instr, 32'd0);
    check("arst_out_addr", {30'd0, out_addr}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    idle(2);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
